// File: rtl/lsu_align_if.sv
// Bundle between the MEM-stage request/response and the dram port of lsu_align.
// slave = the alignment unit; master = whoever drives requests and models dram.
interface lsu_align_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        misaligned_err;
  logic        mem_we;
  logic [1:0]  mem_byte_access;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, misaligned_err,
           mem_we, mem_byte_access, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, misaligned_err,
           mem_we, mem_byte_access, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_align.sv
// Load/store alignment sequencer in front of a 32-bit, 1-cycle-read dram.
// Define LSU_MISALIGNED_EN to split misaligned accesses; otherwise they complete with misaligned_err.
module lsu_align (
  input  logic       clk,
  input  logic       rst_n,
  lsu_align_if.slave bus
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_LD_LO   = 2'd1;
  localparam logic [1:0] S_LD_HI   = 2'd2;
  localparam logic [1:0] S_ST_BYTE = 2'd3;

`ifdef LSU_MISALIGNED_EN
  localparam logic MIS_EN = 1'b1;
`else
  localparam logic MIS_EN = 1'b0;
`endif

  logic [1:0]  r_state;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_lo;
  logic [1:0]  r_size;
  logic [1:0]  r_idx;
  logic        r_unsigned;
  logic        r_cross;

  logic [1:0]  w_next;
  logic [1:0]  w_off;
  logic [2:0]  w_nbytes;
  logic        w_mis;
  logic        w_cross;
  logic [31:0] w_aligned;
  logic [31:0] w_hi_addr;
  logic [4:0]  w_shamt;
  logic [31:0] w_lo_data;
  logic [31:0] w_merged;
  logic [1:0]  w_last;

  logic        w_ready;
  logic        w_rsp_valid;
  logic [31:0] w_rdata;
  logic        w_err;
  logic        w_we;
  logic [1:0]  w_ba;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;

  function automatic logic [31:0] extend(input logic [31:0] d, input logic [1:0] size,
                                         input logic uns);
    case (size)
      2'b00:   return {{24{~uns & d[7]}}, d[7:0]};
      2'b01:   return {{16{~uns & d[15]}}, d[15:0]};
      default: return d;
    endcase
  endfunction

  // dram ByteAccess encoding differs from req_size: 00 word, 01 byte, 10 half.
  function automatic logic [1:0] byte_access(input logic [1:0] size);
    case (size)
      2'b00:   return 2'b01;
      2'b01:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  assign w_off = bus.req_addr[1:0];

  always_comb begin
    case (bus.req_size)
      2'b00:   w_nbytes = 3'd1;
      2'b01:   w_nbytes = 3'd2;
      default: w_nbytes = 3'd4;
    endcase
  end

  assign w_mis   = ((bus.req_size == 2'b01) && w_off[0]) || (bus.req_size[1] && (w_off != 2'b00));
  assign w_cross = ({1'b0, w_off} + w_nbytes) > 3'd4;

  assign w_aligned = {r_addr[31:2], 2'b00};
  assign w_hi_addr = w_aligned + 32'd4;
  assign w_shamt   = {r_addr[1:0], 3'b000};
  assign w_lo_data = bus.mem_rdata >> w_shamt;
  assign w_merged  = 32'({bus.mem_rdata, r_lo} >> w_shamt);
  assign w_last    = (r_size == 2'b00) ? 2'd0 : (r_size == 2'b01) ? 2'd1 : 2'd3;

  // NOTE: every output of this block gets a default first, so no path leaves a latch.
  always_comb begin
    w_next      = r_state;
    w_ready     = 1'b0;
    w_rsp_valid = 1'b0;
    w_rdata     = '0;
    w_err       = 1'b0;
    w_we        = 1'b0;
    w_ba        = 2'b00;
    w_addr      = {bus.req_addr[31:2], 2'b00};
    w_wdata     = '0;
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (bus.req_valid) begin
          if (w_mis && !MIS_EN) begin
            w_rsp_valid = 1'b1;
            w_err       = 1'b1;
          end else if (bus.req_write) begin
            w_we   = 1'b1;
            w_addr = bus.req_addr;
            if (w_mis) begin
              w_ba    = 2'b01;
              w_wdata = {24'd0, bus.req_wdata[7:0]};
              w_next  = S_ST_BYTE;
            end else begin
              w_ba        = byte_access(bus.req_size);
              w_wdata     = bus.req_wdata;
              w_rsp_valid = 1'b1;
            end
          end else begin
            w_next = S_LD_LO;
          end
        end
      end
      S_LD_LO: begin
        if (r_cross) begin
          w_addr = w_hi_addr;
          w_next = S_LD_HI;
        end else begin
          w_addr      = w_aligned;
          w_rsp_valid = 1'b1;
          w_rdata     = extend(w_lo_data, r_size, r_unsigned);
          w_next      = S_IDLE;
        end
      end
      S_LD_HI: begin
        w_addr      = w_hi_addr;
        w_rsp_valid = 1'b1;
        w_rdata     = extend(w_merged, r_size, r_unsigned);
        w_next      = S_IDLE;
      end
      default: begin
        w_we    = 1'b1;
        w_addr  = r_addr + {30'd0, r_idx};
        w_ba    = 2'b01;
        w_wdata = {24'd0, r_wdata[{r_idx, 3'b000} +: 8]};
        if (r_idx == w_last) begin
          w_rsp_valid = 1'b1;
          w_next      = S_IDLE;
        end
      end
    endcase
  end

  // Everything is forced to zero while reset is held, including the combinational IDLE path.
  assign bus.req_ready       = rst_n & w_ready;
  assign bus.rsp_valid       = rst_n & w_rsp_valid;
  assign bus.rsp_rdata       = rst_n ? w_rdata : '0;
  assign bus.misaligned_err  = rst_n & w_err;
  assign bus.mem_we          = rst_n & w_we;
  assign bus.mem_byte_access = rst_n ? w_ba : 2'b00;
  assign bus.mem_addr        = rst_n ? w_addr : '0;
  assign bus.mem_wdata       = rst_n ? w_wdata : '0;

  // NOTE: state uses non-blocking assignments only; every register, lo_q included, is reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_lo       <= '0;
      r_size     <= 2'b00;
      r_idx      <= 2'd0;
      r_unsigned <= 1'b0;
      r_cross    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && bus.req_valid) begin
        r_addr     <= bus.req_addr;
        r_wdata    <= bus.req_wdata;
        r_size     <= bus.req_size;
        r_unsigned <= bus.req_unsigned;
        r_cross    <= w_cross;
        r_idx      <= 2'd1;
      end else if (r_state == S_ST_BYTE) begin
        r_idx <= r_idx + 2'd1;
      end
      if (r_state == S_LD_LO && r_cross) begin
        r_lo <= bus.mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_lsu_align.sv
// Scoreboard bench for lsu_align with a behavioural dram; covers both LSU_MISALIGNED_EN builds.
module tb_lsu_align;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_align_if bus ();

  lsu_align u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // dram: little-endian words, registered read that only updates when MemWrite=0
  logic [31:0] dmem [0:255] = '{default: 32'h0};
  logic [31:0] dram_rdata = 32'h0;
  assign bus.mem_rdata = dram_rdata;

  always @(posedge clk) begin
    if (bus.mem_we) begin
      case (bus.mem_byte_access)
        2'b01:   dmem[bus.mem_addr[9:2]][{bus.mem_addr[1:0], 3'b000} +: 8] <= bus.mem_wdata[7:0];
        2'b10:   dmem[bus.mem_addr[9:2]][{bus.mem_addr[1], 4'b0000} +: 16] <= bus.mem_wdata[15:0];
        default: dmem[bus.mem_addr[9:2]] <= bus.mem_wdata;
      endcase
    end else begin
      dram_rdata <= dmem[bus.mem_addr[9:2]];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   we_cnt   = 0;

  logic        last_we;
  logic [31:0] last_addr;
  logic [31:0] last_wdata;
  logic [1:0]  last_ba;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    int   a;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        acc_q.delete();
      end else begin
        if (bus.mem_we) we_cnt++;
        if (bus.req_valid && bus.req_ready) acc_q.push_back(cyc);
        if (bus.rsp_valid) begin
          check("rsp_expected", 32'(exp_q.size() != 0 && acc_q.size() != 0), 32'd1);
          if (exp_q.size() != 0 && acc_q.size() != 0) begin
            e = exp_q.pop_front();
            a = acc_q.pop_front();
            check("rsp_rdata", bus.rsp_rdata, e.rdata);
            check("rsp_err", 32'(bus.misaligned_err), 32'(e.err));
            check("rsp_latency", 32'(cyc - a), 32'(e.lat));
          end
        end
      end
    end
  endtask

  // Drive one request, hold until accepted, capture the memory port in the accept cycle.
  task automatic send(input logic wr, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err, input int lat,
                      input logic expect_rsp = 1'b1);
    exp_t e;
    logic ok;
    if (expect_rsp) begin
      e.rdata = exp_rd;
      e.err   = exp_err;
      e.lat   = lat;
      exp_q.push_back(e);
    end
    bus.req_valid    = 1'b1;
    bus.req_write    = wr;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wd;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        ok         = 1'b1;
        last_we    = bus.mem_we;
        last_addr  = bus.mem_addr;
        last_wdata = bus.mem_wdata;
        last_ba    = bus.mem_byte_access;
        break;
      end
    end
    check("accept", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  initial begin
    bus.req_valid    = 1'b0;
    bus.req_write    = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    fork
      monitor();
    join_none

    // Reset: a pending store must not leak onto any output
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_size  = 2'b10;
    bus.req_addr  = 32'h0000_0107;
    bus.req_wdata = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(bus.req_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_err", 32'(bus.misaligned_err), 32'd0);
    check("rst_we", 32'(bus.mem_we), 32'd0);
    check("rst_addr", bus.mem_addr, 32'h0);
    check("rst_wdata", bus.mem_wdata, 32'h0);
    check("rst_ba", 32'(bus.mem_byte_access), 32'd0);
    check("rst_rdata", bus.rsp_rdata, 32'h0);
    @(posedge clk);
    #1;
    rst_n         = 1'b1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("idle_ready", 32'(bus.req_ready), 32'd1);
    check("idle_we", 32'(bus.mem_we), 32'd0);
    check("idle_addr", bus.mem_addr, 32'h0000_0104);
    @(posedge clk);
    #1;

    // Aligned stores, back to back
    send(1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'h1122_3344, 32'h0, 1'b0, 0);
    check("sw_we", 32'(last_we), 32'd1);
    check("sw_addr", last_addr, 32'h0000_0100);
    check("sw_wdata", last_wdata, 32'h1122_3344);
    check("sw_ba", 32'(last_ba), 32'd0);
    send(1'b1, 2'b10, 1'b0, 32'h0000_0104, 32'h5566_7788, 32'h0, 1'b0, 0);
    send(1'b1, 2'b00, 1'b0, 32'h0000_010B, 32'hFFFF_FF5A, 32'h0, 1'b0, 0);
    check("sb_ba", 32'(last_ba), 32'd1);
    check("sb_addr", last_addr, 32'h0000_010B);
    send(1'b1, 2'b01, 1'b0, 32'h0000_010C, 32'h0000_9876, 32'h0, 1'b0, 0);
    check("sh_ba", 32'(last_ba), 32'd2);
    send(1'b1, 2'b10, 1'b0, 32'hFFFF_FFFC, 32'hA1B2_C3D4, 32'h0, 1'b0, 0);

    // Aligned loads with sign/zero extension
    send(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 32'h1122_3344, 1'b0, 1);
    check("lw_we", 32'(last_we), 32'd0);
    send(1'b0, 2'b00, 1'b0, 32'h0000_0104, 32'h0, 32'hFFFF_FF88, 1'b0, 1);
    send(1'b0, 2'b00, 1'b1, 32'h0000_0100, 32'h0, 32'h0000_0044, 1'b0, 1);
    send(1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'h0, 32'h0000_1122, 1'b0, 1);
    send(1'b0, 2'b01, 1'b0, 32'h0000_0106, 32'h0, 32'h0000_5566, 1'b0, 1);
    send(1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0, 32'h0000_0011, 1'b0, 1);
    send(1'b0, 2'b10, 1'b0, 32'h0000_0108, 32'h0, 32'h5A00_0000, 1'b0, 1);
    send(1'b0, 2'b01, 1'b0, 32'h0000_010C, 32'h0, 32'hFFFF_9876, 1'b0, 1);
    send(1'b0, 2'b01, 1'b1, 32'h0000_010C, 32'h0, 32'h0000_9876, 1'b0, 1);
    send(1'b0, 2'b10, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'hA1B2_C3D4, 1'b0, 1);
    send(1'b0, 2'b11, 1'b1, 32'h0000_0104, 32'h0, 32'h5566_7788, 1'b0, 1);

`ifdef LSU_MISALIGNED_EN
    // Crossing word load: two reads, ready low for two cycles
    send(1'b0, 2'b10, 1'b0, 32'h0000_0102, 32'h0, 32'h7788_1122, 1'b0, 2);
    @(negedge clk);
    check("cross_ready_lo", 32'(bus.req_ready), 32'd0);
    check("cross_hi_addr", bus.mem_addr, 32'h0000_0104);
    check("cross_we", 32'(bus.mem_we), 32'd0);
    @(negedge clk);
    check("cross_ready_hi", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #1;
    send(1'b0, 2'b01, 1'b0, 32'h0000_0103, 32'h0, 32'hFFFF_8811, 1'b0, 2);
    send(1'b0, 2'b01, 1'b1, 32'h0000_0103, 32'h0, 32'h0000_8811, 1'b0, 2);
    send(1'b0, 2'b01, 1'b0, 32'h0000_0101, 32'h0, 32'h0000_2233, 1'b0, 1);

    // Misaligned half store split into two byte writes
    send(1'b1, 2'b01, 1'b0, 32'h0000_0103, 32'h0000_ABCD, 32'h0, 1'b0, 1);
    check("msh_b0_we", 32'(last_we), 32'd1);
    check("msh_b0_addr", last_addr, 32'h0000_0103);
    check("msh_b0_data", last_wdata, 32'h0000_00CD);
    check("msh_b0_ba", 32'(last_ba), 32'd1);
    @(negedge clk);
    check("msh_b1_we", 32'(bus.mem_we), 32'd1);
    check("msh_b1_addr", bus.mem_addr, 32'h0000_0104);
    check("msh_b1_data", bus.mem_wdata, 32'h0000_00AB);
    @(posedge clk);
    #1;
    send(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 32'hCD22_3344, 1'b0, 1);
    send(1'b0, 2'b10, 1'b0, 32'h0000_0104, 32'h0, 32'h5566_77AB, 1'b0, 1);

    // Reset after the second byte of a misaligned word store
    send(1'b1, 2'b10, 1'b0, 32'h0000_0101, 32'hDEAD_BEEF, 32'h0, 1'b0, 0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("abort_we", 32'(bus.mem_we), 32'd0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_ready", 32'(bus.req_ready), 32'd1);
    check("abort_we_after", 32'(bus.mem_we), 32'd0);
    check("abort_no_rsp", 32'(bus.rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    send(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 32'hCDBE_EF44, 1'b0, 1);
    send(1'b0, 2'b10, 1'b0, 32'h0000_0104, 32'h0, 32'h5566_77AB, 1'b0, 1);

    // Misaligned word store (three extra cycles) and a crossing load that wraps the address
    send(1'b1, 2'b10, 1'b0, 32'h0000_010D, 32'h0A0B_0C0D, 32'h0, 1'b0, 3);
    send(1'b0, 2'b10, 1'b0, 32'h0000_010C, 32'h0, 32'h0B0C_0D76, 1'b0, 1);
    send(1'b0, 2'b10, 1'b0, 32'h0000_0110, 32'h0, 32'h0000_000A, 1'b0, 1);
    send(1'b1, 2'b10, 1'b0, 32'h0000_0000, 32'h0102_0304, 32'h0, 1'b0, 0);
    send(1'b0, 2'b10, 1'b0, 32'hFFFF_FFFE, 32'h0, 32'h0304_A1B2, 1'b0, 2);
`else
    // Misaligned accesses are rejected in the accept cycle with no memory write
    begin
      int w0;
      w0 = we_cnt;
      send(1'b0, 2'b10, 1'b0, 32'h0000_0102, 32'h0, 32'h0, 1'b1, 0);
      check("mis_ld_we", 32'(last_we), 32'd0);
      send(1'b1, 2'b01, 1'b0, 32'h0000_0103, 32'h0000_ABCD, 32'h0, 1'b1, 0);
      check("mis_sh_we", 32'(last_we), 32'd0);
      send(1'b0, 2'b01, 1'b0, 32'h0000_0101, 32'h0, 32'h0, 1'b1, 0);
      send(1'b1, 2'b10, 1'b0, 32'h0000_0101, 32'hDEAD_BEEF, 32'h0, 1'b1, 0);
      check("mis_no_write", 32'(we_cnt - w0), 32'd0);
    end
    send(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 32'h1122_3344, 1'b0, 1);
    send(1'b0, 2'b10, 1'b0, 32'h0000_0104, 32'h0, 32'h5566_7788, 1'b0, 1);
    send(1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'h0, 32'h0000_1122, 1'b0, 1);
`endif

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lsu_align.md
# lsu_align

Load/store alignment sequencer between the MEM-stage pipeline request and the data RAM (`dram`). Translates byte/half/word loads and stores into `dram` accesses on its `MemWrite`/`ByteAccess`/address/`WriteData` ports and sign/zero-extends returned load data. Misaligned accesses are split into multiple `dram` cycles, with `req_ready` low while busy. Misaligned support is compile-time optional.

## Interface
- No parameters. `dram` geometry is fixed: 32-bit words, byte address, 1-cycle registered read.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present; held stable until accepted.
- `req_ready`  out  1  request accepted when `req_valid && req_ready`.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- `req_unsigned`  in  1  load zero-extends when 1, sign-extends when 0; ignored for stores.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `rsp_valid`  out  1  one-cycle completion pulse, for loads and stores.
- `rsp_rdata`  out  32  extended load data; 0 for stores and errors.
- `misaligned_err`  out  1  pulses with `rsp_valid` on a rejected access; tied 0 when the macro is defined.
- `mem_we`  out  1  to `dram` `MemWrite`.
- `mem_byte_access`  out  2  to `dram` `ByteAccess`: 00 word, 01 byte, 10 half.
- `mem_addr`  out  32  to `dram` `ALUResult`.
- `mem_wdata`  out  32  to `dram` `WriteData`.
- `mem_rdata`  in  32  from `dram` `ReadData`; valid the cycle after a read address is presented.

## Operation
- States: IDLE, LD_LO, LD_HI, ST_BYTE.
- Definitions: `off = req_addr[1:0]`; `nbytes` = 1, 2 or 4.
  - An access is misaligned when it is a half with `off[0]=1`, or a word with `off!=0`.
  - A load crosses a word boundary when `off + nbytes > 4`.
- IDLE:
  - `req_ready=1`. Memory outputs are combinational from the request fields.
  - Idle, or not accepting a request: `mem_we=0` and `mem_addr={req_addr[31:2],2'b00}`.
- Aligned store:
  - Accept cycle drives `mem_we=1`, `mem_addr=req_addr`, size mapped to `mem_byte_access`, and `mem_wdata=req_wdata`.
  - `rsp_valid=1` in the same cycle. Stay in IDLE.
- Misaligned store (macro defined):
  - Split into `nbytes` sb writes, byte k to `req_addr+k` with `mem_wdata[7:0]=req_wdata[8k+7:8k]` and `mem_byte_access=01`.
  - Byte 0 is written in the accept cycle; the remaining bytes are written in ST_BYTE, one per cycle.
  - `rsp_valid` is asserted on the last write cycle, then the unit returns to IDLE.
- Load, no crossing:
  - Accept cycle reads the aligned word; next state is LD_LO.
  - In LD_LO: `rsp_rdata = extend(mem_rdata >> 8*off)`, `rsp_valid=1`, then IDLE.
- Crossing load (macro defined):
  - The first word is read in the accept cycle.
  - In LD_LO, capture `mem_rdata` into `lo_q` and read word `{addr[31:2],2'b00}+4`; next state is LD_HI.
  - In LD_HI, merge `{mem_rdata,lo_q} >> 8*off`, extend to 32 bits, pulse `rsp_valid`, then IDLE.
- `mem_we=0` throughout loads (`dram` only updates `ReadData` when `MemWrite=0`).
- Address arithmetic is modulo 2^32; `0xFFFFFFFC+4` wraps to 0.
- Request fields (addr, size, unsigned, wdata, byte index) are latched on accept. Non-IDLE states use only the latched copies.

## Timing
- Reset values: state IDLE; `rsp_valid=0`, `misaligned_err=0`, `mem_we=0`, `rsp_rdata=0`, `mem_wdata=0`, `mem_addr=0`, `mem_byte_access=00`, `lo_q=0`. `req_ready=0` while `rst_n=0`.
- Latency from accept to `rsp_valid`:
  - aligned store: 0 cycles; back-to-back every cycle.
  - misaligned store: `nbytes-1` cycles.
  - load without crossing: 1 cycle.
  - crossing load: 2 cycles.
- `req_ready=0` in every non-IDLE state; `req_valid` there is ignored.
- Reset asserted mid-sequence:
  - The sequence is abandoned immediately and no `rsp_valid` is produced.
  - Bytes already written stay in `dram`.

## Configuration
- `LSU_MISALIGNED_EN` defined: misaligned stores and crossing loads are split as above; `misaligned_err` is tied 0.
- Undefined: any misaligned access (load or store) makes no memory access (`mem_we=0`). It completes in the accept cycle with `rsp_valid=1`, `misaligned_err=1` and `rsp_rdata=0`. Non-crossing aligned behaviour is unchanged.

## Test plan
- sw 0x11223344 @0x100, then sw 0x55667788 @0x104; lw @0x100 -> `rsp_rdata=0x11223344` one cycle after accept.
- Same memory; lb signed @0x104 -> 0xFFFFFF88; lbu @0x100 -> 0x00000044; lhu @0x102 -> 0x00001122.
- Macro on, lw @0x102 -> reads 0x100 then 0x104; `rsp_rdata=0x77881122` two cycles after accept; `req_ready=0` for 2 cycles.
- Macro on, lh signed @0x103 -> 0xFFFF8811; sh 0xABCD @0x103 -> byte writes 0xCD@0x103, 0xAB@0x104; then lw @0x100 = 0xCD223344 and lw @0x104 = 0x556677AB.
- Macro on, sw @0x101, `rst_n` pulsed low after the 2nd byte write -> no `rsp_valid`, `mem_we=0`, `req_ready=1` after release; exactly 2 bytes modified.
- Macro off, lw @0x102 -> `rsp_valid=1`, `misaligned_err=1`, `rsp_rdata=0`, no `mem_we`; next aligned lw @0x100 is serviced normally.
